waveform_reader: RTL and testbench

Reads a captured waveform out of the sample buffer and serializes it as a framed byte stream for the UART transmitter. It sits between the trigger-driven capture buffer (14-bit samples, 1000 deep) and the UART TX. On each `start` pulse it emits one frame: a sync header, the 16-bit waveform number, every sample as two bytes, and an XOR checksum.

---
 rtl/waveform_reader.sv | 130 +++++++++++++
 tb/tb_waveform_reader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_reader.sv
// Serializes one captured waveform per start pulse into a framed byte stream:
// AA 55, WN hi/lo, each sample hi/lo (zero-extended to 16 bits), XOR checksum.
module waveform_reader #(
  parameter int NUM_SAMPLES = 1000,
  parameter int SAMPLE_W    = 14,
  parameter int ADDR_W      = 10
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_start,
  input  logic [15:0]         i_wave_number,
  output logic                o_rd_en,
  output logic [ADDR_W-1:0]   o_rd_addr,
  input  logic [SAMPLE_W-1:0] i_rd_data,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  output logic                o_busy,
  output logic                o_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC0, S_SYNC1, S_WNH, S_WNL,
    S_FETCH, S_WAIT, S_SH, S_SL, S_CK, S_FIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SAMPLES - 1);

  state_t            r_state;
  logic [15:0]       r_wn;
  logic [7:0]        r_ck;
  logic [7:0]        r_sample_lo;
  logic [ADDR_W-1:0] r_idx;

  logic        w_hs;
  logic [15:0] w_rd16;
  logic [7:0]  w_ck_nxt;

  assign w_hs     = o_tx_valid && i_tx_ready;
  assign w_rd16   = 16'(i_rd_data);
  // Running checksum including the byte being accepted this cycle.
  assign w_ck_nxt = r_ck ^ o_tx_data;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_wn        <= '0;
      r_ck        <= '0;
      r_sample_lo <= '0;
      r_idx       <= '0;
      o_rd_en     <= 1'b0;
      o_rd_addr   <= '0;
      o_tx_data   <= '0;
      o_tx_valid  <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_rd_en <= 1'b0;
      o_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_wn       <= i_wave_number;
            r_ck       <= '0;
            r_idx      <= '0;
            o_busy     <= 1'b1;
            o_tx_valid <= 1'b1;
            o_tx_data  <= 8'hAA;
            r_state    <= S_SYNC0;
          end
        end
        S_SYNC0: if (w_hs) begin
          o_tx_data <= 8'h55;
          r_state   <= S_SYNC1;
        end
        S_SYNC1: if (w_hs) begin
          o_tx_data <= r_wn[15:8];
          r_state   <= S_WNH;
        end
        S_WNH: if (w_hs) begin
          r_ck      <= w_ck_nxt;
          o_tx_data <= r_wn[7:0];
          r_state   <= S_WNL;
        end
        S_WNL: if (w_hs) begin
          r_ck       <= w_ck_nxt;
          o_tx_valid <= 1'b0;
          o_rd_en    <= 1'b1;
          o_rd_addr  <= r_idx;
          r_state    <= S_FETCH;
        end
        S_FETCH: r_state <= S_WAIT;
        S_WAIT: begin
          // Buffer data is valid in this cycle only; keep the low byte for SL.
          r_sample_lo <= w_rd16[7:0];
          o_tx_valid  <= 1'b1;
          o_tx_data   <= w_rd16[15:8];
          r_state     <= S_SH;
        end
        S_SH: if (w_hs) begin
          r_ck      <= w_ck_nxt;
          o_tx_data <= r_sample_lo;
          r_state   <= S_SL;
        end
        S_SL: if (w_hs) begin
          r_ck <= w_ck_nxt;
          if (r_idx < LAST_IDX) begin
            r_idx      <= r_idx + ADDR_W'(1);
            o_rd_addr  <= r_idx + ADDR_W'(1);
            o_rd_en    <= 1'b1;
            o_tx_valid <= 1'b0;
            r_state    <= S_FETCH;
          end else begin
            o_tx_data <= w_ck_nxt;
            r_state   <= S_CK;
          end
        end
        S_CK: if (w_hs) begin
          o_tx_valid <= 1'b0;
          o_busy     <= 1'b0;
          o_done     <= 1'b1;
          r_state    <= S_FIN;
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_waveform_reader.sv
// Directed bench: ramp frames, backpressure, busy-start, mid-frame reset,
// back-to-back frames and a 2-sample masking frame on a second instance.
module tb_waveform_reader;

  logic        clk = 1'b0;
  logic        reset_n, start, start2, tx_ready = 1'b0;
  logic [15:0] wave_number;
  logic        rd_en, tx_valid, busy, done;
  logic [9:0]  rd_addr;
  logic [13:0] rd_data = '0;
  logic [7:0]  tx_data;
  logic        rd_en2, tx_valid2, busy2, done2;
  logic [9:0]  rd_addr2;
  logic [13:0] rd_data2 = '0;
  logic [7:0]  tx_data2;

  logic rdy, bp;
  int   n_chk = 0, n_pass = 0;
  int   n_done = 0, act_cyc = 0, n_unstable = 0;
  logic p_stall = 1'b0;
  logic [7:0] p_data = '0;
  logic [7:0] got[$];
  logic [7:0] got2[$];
  logic [7:0] exp_q[$];

  waveform_reader u_dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_wave_number(wave_number),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_busy(busy), .o_done(done));

  waveform_reader #(.NUM_SAMPLES(2)) u_dut2 (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start2), .i_wave_number(wave_number),
    .o_rd_en(rd_en2), .o_rd_addr(rd_addr2), .i_rd_data(rd_data2),
    .o_tx_data(tx_data2), .o_tx_valid(tx_valid2), .i_tx_ready(tx_ready),
    .o_busy(busy2), .o_done(done2));

  always #5 clk = ~clk;

  // Buffer models: registered read, ramp for the main instance.
  always @(posedge clk) begin
    if (rd_en)  rd_data  <= 14'(rd_addr);
    if (rd_en2) rd_data2 <= (rd_addr2 == 10'd0) ? 14'h3FFF : 14'h2A5A;
  end

  always @(negedge clk) begin
    if (tx_valid && tx_ready) got.push_back(tx_data);
    if (tx_valid2 && tx_ready) got2.push_back(tx_data2);
    if (done) n_done <= n_done + 1;
    if (busy || done) act_cyc <= act_cyc + 1;
    if (reset_n && p_stall && (!tx_valid || tx_data != p_data)) n_unstable <= n_unstable + 1;
    p_stall <= reset_n && tx_valid && !tx_ready;
    p_data  <= tx_data;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp) tx_ready = ($urandom_range(0, 99) < 30);
      else    tx_ready = rdy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  function automatic void build(input logic [15:0] w);
    logic [7:0]  ck;
    logic [15:0] s;
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    ck = w[15:8] ^ w[7:0];
    for (int i = 0; i < 1000; i++) begin
      s = 16'(i) & 16'h3FFF;
      exp_q.push_back(s[15:8]);
      exp_q.push_back(s[7:0]);
      ck = ck ^ s[15:8] ^ s[7:0];
    end
    exp_q.push_back(ck);
  endfunction

  task automatic cmp_stream(input string tag, input int base);
    int len, k;
    len = got.size() - base;
    chk({tag, "_len"}, len, exp_q.size());
    k = 0;
    while (k < len - 1 && k < exp_q.size() - 1 && got[base+k] == exp_q[k]) k++;
    if (len > 0) chk({tag, "_bytes"}, got[base+k], exp_q[k]);
  endtask

  task automatic pulse(input logic [15:0] w);
    @(posedge clk); #1;
    wave_number = w;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wave_number = ~w;  // must not leak into the frame in flight
  endtask

  task automatic wait_done(input string tag, input int bound);
    int c = 0;
    while (done !== 1'b1 && c < bound) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic wait_bytes(input string tag, input int base, input int n);
    int c = 0;
    while (got.size() - base < n && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_reach"}, (got.size() - base >= n), 1);
  endtask

  initial begin
    int base, bd, ba, bu;
    logic [7:0] exp2 [9];
    reset_n = 1'b0; start = 1'b0; start2 = 1'b0; wave_number = '0; rdy = 1'b1; bp = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_rden", rd_en, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full ramp frame, tx_ready held high.
    base = got.size(); bd = n_done; ba = act_cyc;
    pulse(16'h0123);
    @(negedge clk);
    chk("t1_lat_valid", tx_valid, 1);
    chk("t1_lat_aa", tx_data, 8'hAA);
    chk("t1_busy", busy, 1);
    wait_done("t1", 6000);
    repeat (2) @(negedge clk);
    exp_q.delete(); build(16'h0123);
    cmp_stream("t1", base);
    chk("t1_ck", got[got.size()-1], 8'h22);
    chk("t1_ndone", n_done - bd, 1);
    chk("t1_cycles", act_cyc - ba, 4006);
    chk("t1_idle_busy", busy, 0);

    // Backpressure at 30% ready duty.
    base = got.size(); bd = n_done; bu = n_unstable;
    bp = 1'b1;
    pulse(16'h0123);
    wait_done("t2", 30000);
    bp = 1'b0;
    repeat (2) @(negedge clk);
    cmp_stream("t2", base);
    chk("t2_stable", n_unstable - bu, 0);
    chk("t2_ndone", n_done - bd, 1);

    // Start while busy is ignored.
    base = got.size(); bd = n_done;
    pulse(16'h0123);
    wait_bytes("t3", base, 500);
    @(posedge clk); #1; start = 1'b1; wave_number = 16'hFFFF;
    @(posedge clk); #1; start = 1'b0;
    wait_done("t3", 6000);
    repeat (30) @(negedge clk);
    cmp_stream("t3", base);
    chk("t3_ndone", n_done - bd, 1);
    chk("t3_idle", busy, 0);

    // Reset during sample 300.
    base = got.size();
    pulse(16'h0123);
    wait_bytes("t4", base, 4 + 2*300 + 1);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("t4_valid", tx_valid, 0);
    chk("t4_data", tx_data, 0);
    chk("t4_rden", rd_en, 0);
    chk("t4_addr", rd_addr, 0);
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    base = got.size();
    pulse(16'h0123);
    wait_done("t4b", 6000);
    repeat (2) @(negedge clk);
    cmp_stream("t4b", base);
    chk("t4b_first", got[base], 8'hAA);

    // Back-to-back: second start in the cycle after done.
    base = got.size(); bd = n_done;
    pulse(16'h0123);
    wait_done("t5a", 6000);
    @(posedge clk); #1; start = 1'b1; wave_number = 16'hBEEF;
    @(posedge clk); #1; start = 1'b0; wave_number = 16'h0000;
    @(negedge clk);
    chk("t5_accept", tx_valid, 1);
    wait_done("t5b", 6000);
    repeat (2) @(negedge clk);
    exp_q.delete(); build(16'h0123); build(16'hBEEF);
    cmp_stream("t5", base);
    chk("t5_ck2", got[got.size()-1], 8'h51);
    chk("t5_ndone", n_done - bd, 2);

    // Two-sample instance: zero-extension and checksum.
    exp2 = '{8'hAA, 8'h55, 8'h80, 8'h01, 8'h3F, 8'hFF, 8'h2A, 8'h5A, 8'h31};
    @(posedge clk); #1; start2 = 1'b1; wave_number = 16'h8001;
    @(posedge clk); #1; start2 = 1'b0; wave_number = 16'h0000;
    begin
      int c = 0;
      while (done2 !== 1'b1 && c < 100) begin @(negedge clk); c++; end
    end
    chk("t6_done", done2, 1);
    repeat (2) @(negedge clk);
    chk("t6_len", got2.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < got2.size()) chk($sformatf("t6_b%0d", i), got2[i], exp2[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
